// File: rtl/spi_slave_rx_if.sv
// Receive-side bus of the SPI slave receiver: FIFO read port, status and
// sticky error flags. The consumer uses the master modport, the receiver
// uses the slave modport.
interface spi_slave_rx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             rd_en;
    logic             clr_err;
    logic [7:0]       rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             overflow;
    logic             frame_err;

    modport master (
        output rd_en, clr_err,
        input  rd_data, empty, full, count, busy, overflow, frame_err
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, empty, full, count, busy, overflow, frame_err
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver. The SPI pins are oversampled by the system
// clock through equal-depth synchronizers; bytes are assembled MSB first
// and pushed into a small show-ahead FIFO read through the bus interface.
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sclk_in,
    input  logic            mosi_in,
    input  logic            cs_in,
    spi_slave_rx_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Synchronizer chains; index SYNC_STAGES-1 is the synchronized output.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic sclk_rise;

    // FSM and byte assembly
    state_t     state_q;
    state_t     state_d;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       frame_start;
    logic       frame_abort;
    logic       sample;
    logic       byte_done;
    logic [7:0] rx_byte;

    // FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;

    // Sticky error flags
    logic overflow_q;
    logic frame_err_q;

    // Shift the asynchronous SPI pins through identical-depth synchronizers;
    // cs idles deasserted (1), sclk and mosi idle low.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour, giving a real chain.
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_in};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle control strobes for the datapath.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        frame_start = 1'b0;
        frame_abort = 1'b0;
        sample      = 1'b0;
        case (state_q)
            IDLE: begin
                // sclk edges are deliberately ignored until cs is asserted.
                if (!cs_s) begin
                    state_d     = RECV;
                    frame_start = 1'b1;
                end
            end
            RECV: begin
                if (cs_s) begin
                    state_d     = IDLE;
                    frame_abort = (bit_cnt_q != 3'd0);
                end else if (sclk_rise) begin
                    sample = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign byte_done = sample && (bit_cnt_q == 3'd7);
    assign rx_byte   = {shift_q, mosi_s};

    // Bit counter and shift register; a frame start or end discards any
    // partial byte, and the 3-bit counter wraps to 0 after the 8th bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
        end else if (frame_start || (state_q == RECV && cs_s)) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
        end else if (sample) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            shift_q   <= {shift_q[5:0], mosi_s};
        end
    end

    // FIFO control: a pop on an empty FIFO is ignored; a completed byte on a
    // full FIFO is accepted only if the head is popped in the same cycle.
    assign fifo_empty = (count_q == CNT_W'(0));
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = bus.rd_en && !fifo_empty;
    assign push       = byte_done && (!fifo_full || pop);
    assign drop       = byte_done && fifo_full && !bus.rd_en;

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; entries are only observable
        // through count/rd_ptr, which are reset, and rd_data is forced to 0
        // while empty.
        if (push) begin
            mem[wr_ptr_q] <= rx_byte;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (frame_abort) begin
                frame_err_q <= 1'b1;
            end else if (bus.clr_err) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    assign bus.rd_data   = fifo_empty ? 8'h00 : mem[rd_ptr_q];
    assign bus.empty     = fifo_empty;
    assign bus.full      = fifo_full;
    assign bus.count     = count_q;
    assign bus.busy      = (state_q == RECV);
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Testbench for spi_slave_rx: an SPI master model drives frames, a queue
// holds the bytes the receiver should deliver, and a monitor drains the
// FIFO and compares every delivered byte against the queue head.
module tb_spi_slave_rx;
    localparam int SYNC       = 2;
    localparam int DEPTH      = 4;
    localparam int HALF_SLOW  = 50;   // sclk = clk/100
    localparam int HALF_FAST  = 8;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic sclk     = 1'b0;
    logic mosi     = 1'b0;
    logic cs       = 1'b1;
    logic clr      = 1'b0;
    logic mon_rd   = 1'b0;
    logic force_rd = 1'b0;
    logic mon_en   = 1'b0;

    spi_slave_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    assign bus.rd_en   = mon_rd | force_rd;
    assign bus.clr_err = clr;

    spi_slave_rx #(
        .SYNC_STAGES (SYNC),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk_in (sclk),
        .mosi_in (mosi),
        .cs_in   (cs),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovf  = 1'b0;
    bit         exp_ferr = 1'b0;
    int         half     = HALF_FAST;
    int         frame_bits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a completed byte enters the FIFO unless it is full
    // and nothing is popped in that cycle, in which case it is lost.
    task automatic model_byte(input logic [7:0] b, input bit rd_same_cycle);
        if (exp_q.size() < DEPTH || rd_same_cycle) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        frame_bits = 0;
        wait_clk(half);
    endtask

    task automatic cs_high();
        wait_clk(half);
        cs = 1'b1;
        if (frame_bits % 8 != 0) exp_ferr = 1'b1;
        frame_bits = 0;
        wait_clk(SYNC + 3);
    endtask

    // Send the top nbits of b, MSB first. lat_chk watches empty around the
    // byte-complete edge; rd_coin pops the head in the byte-complete cycle.
    task automatic send_bits(input logic [7:0] b, input int nbits,
                             input bit lat_chk = 1'b0, input bit rd_coin = 1'b0);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            wait_clk(half);
            sclk = 1'b1;
            frame_bits++;
            if (frame_bits % 8 == 0) begin
                model_byte(b, rd_coin);
                for (int k = 1; k <= SYNC + 1; k++) begin
                    @(negedge clk);
                    if (lat_chk) check("empty_latency", bus.empty, (k <= SYNC));
                    if (rd_coin && k == SYNC) begin
                        check("coincident_head", bus.rd_data, exp_q.pop_front());
                        force_rd = 1'b1;
                    end
                    if (k == SYNC + 1) force_rd = 1'b0;
                end
                wait_clk(half - (SYNC + 1));
            end else begin
                wait_clk(half);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic clear_err();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    // Wait (bounded) until the monitor has consumed every expected byte.
    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && bus.empty) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("drain_timeout", exp_q.size(), 0);
        wait_clk(2);
        check("drained_empty", bus.empty, 1);
        check("drained_rd_data", bus.rd_data, 8'h00);
        check("drained_count", bus.count, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"},     bus.empty,     1);
        check({tag, "_full"},      bus.full,      0);
        check({tag, "_count"},     bus.count,     0);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_rd_data"},   bus.rd_data,   8'h00);
        check({tag, "_overflow"},  bus.overflow,  0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
    endtask

    // Monitor: whenever enabled and the FIFO shows data, compare the head
    // with the oldest expected byte and pop it.
    always @(negedge clk) begin
        if (mon_en && !bus.empty) begin
            if (exp_q.size() == 0) check("spurious_byte", bus.count, 0);
            else check("fifo_data", bus.rd_data, exp_q.pop_front());
            mon_rd = 1'b1;
        end else begin
            mon_rd = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int nb;

        // Reset
        wait_clk(3);
        check_reset_outputs("in_reset");
        rst = 1'b0;
        wait_clk(3);
        check_reset_outputs("after_reset");

        // Single byte at clk/100 with empty-deassert latency
        half = HALF_SLOW;
        cs_low();
        check("busy_in_frame", bus.busy, 1);
        send_bits(8'hA5, 8, 1'b1, 1'b0);
        cs_high();
        check("a5_count", bus.count, 1);
        check("a5_rd_data", bus.rd_data, 8'hA5);
        check("a5_overflow", bus.overflow, 0);
        check("a5_frame_err", bus.frame_err, 0);
        check("a5_busy", bus.busy, 0);
        half = HALF_FAST;
        mon_en = 1'b1;
        drain();

        // Three bytes in one frame, popped in order
        cs_low();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        cs_high();
        drain();

        // Overflow: five bytes, no reads
        mon_en = 1'b0;
        cs_low();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_byte(b);
        end
        cs_high();
        check("ovf_full", bus.full, 1);
        check("ovf_count", bus.count, 4);
        check("ovf_flag", bus.overflow, exp_ovf);
        check("ovf_head", bus.rd_data, exp_q[0]);
        clear_err();
        check("ovf_cleared", bus.overflow, 0);

        // Full FIFO, pop coinciding with byte completion
        cs_low();
        send_bits(8'h5A, 8, 1'b0, 1'b1);
        cs_high();
        check("coin_count", bus.count, 4);
        check("coin_full", bus.full, 1);
        check("coin_overflow", bus.overflow, exp_ovf);
        mon_en = 1'b1;
        drain();

        // Frame error after five bits, then a good byte
        cs_low();
        send_bits(8'hE8, 5);
        cs_high();
        check("ferr_flag", bus.frame_err, exp_ferr);
        check("ferr_count", bus.count, 0);
        clear_err();
        check("ferr_cleared", bus.frame_err, 0);
        cs_low();
        send_byte(8'h3C);
        cs_high();
        check("3c_frame_err", bus.frame_err, 0);
        drain();

        // Reset mid-frame after four bits
        mon_en = 1'b0;
        cs_low();
        send_bits(8'hC3, 4);
        @(negedge clk);
        rst = 1'b1;
        frame_bits = 0;
        wait_clk(2);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        wait_clk(1);
        check("post_reset_frame_err", bus.frame_err, 0);
        cs_high();
        check("post_reset_cs_high_ferr", bus.frame_err, 0);
        mon_en = 1'b1;
        cs_low();
        send_byte(8'hFF);
        cs_high();
        drain();

        // Randomized frames, some ending with a partial byte
        for (int f = 0; f < 12; f++) begin
            cs_low();
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                send_byte(b);
            end
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
                send_bits(b, $urandom_range(1, 7));
            end
            cs_high();
            check("rand_frame_err", bus.frame_err, exp_ferr);
            check("rand_overflow", bus.overflow, exp_ovf);
            drain();
            if (exp_ferr) clear_err();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning input synchronizer depth (legal values 2..3).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port sclk_in, input, 1 bit, meaning the SPI clock from the master; asynchronous to clk; mode 0.
REQ-006 SHALL have port mosi_in, input, 1 bit, meaning serial data from the master, MSB first; asynchronous.
REQ-007 SHALL have port cs_in, input, 1 bit, meaning chip select; active-low; asynchronous.
REQ-008 SHALL have port rd_en, input, 1 bit, meaning pop the FIFO head.
REQ-009 SHALL have port clr_err, input, 1 bit, meaning clear both sticky error flags.
REQ-010 SHALL have port rd_data, output, 8 bits, meaning the FIFO head entry (show-ahead).
REQ-011 SHALL have ports empty and full, outputs, 1 bit each, meaning the FIFO status.
REQ-012 SHALL have port count, output, log2(FIFO_DEPTH)+1 bits, meaning the number of occupied entries.
REQ-013 SHALL have port busy, output, 1 bit, meaning the FSM is in RECV.
REQ-014 SHALL have ports overflow and frame_err, outputs, 1 bit each, meaning sticky error flags.

Function
REQ-015 SHALL pass sclk_in, mosi_in and cs_in each through SYNC_STAGES flops; the synchronizer depth SHALL be identical for all three.
REQ-016 SHALL register the synchronized sclk once more; a rising edge SHALL be detected as synced=1 and previous=0.
REQ-017 SHALL implement a two-state FSM with states IDLE and RECV.
REQ-018 SHALL transition IDLE->RECV when synchronized cs is 0, clearing the bit counter (0..7) and the shift register.
REQ-019 SHALL transition RECV->IDLE when synchronized cs is 1.
REQ-020 SHALL ignore sclk edges while in IDLE.
REQ-021 SHALL, in RECV on a detected rising edge, shift synchronized mosi into the LSB of the shift register (left shift) and increment the bit counter.
REQ-022 SHALL, on the 8th rising edge of a byte, write {shift[6:0], mosi_sync} to the FIFO on that same clk edge and wrap the bit counter to 0; back-to-back bytes within one CS frame are supported.
REQ-023 SHALL deassert empty on the clk edge SYNC_STAGES cycles after the first clk edge that samples the 8th sclk_in rising edge as high.
REQ-024 SHALL, when a byte completes while full=1 and rd_en=0, drop the byte, leave the FIFO unchanged and set overflow.
REQ-025 SHALL, when a byte completes while full=1 and rd_en=1, perform both pop and push with no overflow and count unchanged.
REQ-026 SHALL ignore rd_en while empty=1; count SHALL never underflow.
REQ-027 SHALL drive rd_data to the oldest entry when empty=0 and to 8'h00 when empty=1.
REQ-028 SHALL, on RECV->IDLE with bit counter != 0, discard the partial byte and set frame_err.
REQ-029 SHALL, on RECV->IDLE with bit counter == 0, raise no error.
REQ-030 SHALL clear overflow and frame_err on clr_err=1; a set condition in the same cycle as clr_err SHALL win, so the flag stays 1.
REQ-031 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; full SHALL be (count==FIFO_DEPTH) and empty SHALL be (count==0).
REQ-032 SHALL derive busy as state==RECV.

Reset
REQ-033 SHALL, with rst=1 at a clk edge, force the state to IDLE; clear the bit counter, shift register, FIFO pointers, count, overflow and frame_err; and preset all synchronizer flops for cs to 1 and for sclk/mosi to 0.
REQ-034 SHALL hold empty=1, full=0, count=0, busy=0, rd_data=8'h00, overflow=0 and frame_err=0 during reset and after reset.
REQ-035 SHALL discard any in-flight partial byte when reset is asserted mid-frame, without setting frame_err.

Verification
REQ-036 SHALL cover: CS low, byte 8'hA5 at sclk = clk/100, CS high -> count=1, rd_data=8'hA5, no errors, empty low exactly SYNC_STAGES edges after the 8th sclk rise is sampled.
REQ-037 SHALL cover: one CS frame carrying 8'h01,8'h02,8'h03 -> FIFO pops in order 01,02,03, then empty=1 and rd_data=8'h00.
REQ-038 SHALL cover: 5 bytes with no reads (FIFO_DEPTH=4) -> full=1, count=4, overflow=1, FIFO holds the first 4 bytes; clr_err -> overflow=0.
REQ-039 SHALL cover: CS high after 5 bits -> frame_err=1, count unchanged; the next full byte 8'h3C is received correctly.
REQ-040 SHALL cover: full FIFO, with rd_en coinciding with a byte-complete cycle -> count stays 4, no overflow, new byte at the tail.
REQ-041 SHALL cover: rst pulsed after 4 bits with clr_err=0 -> all outputs at reset values, frame_err=0; the next byte 8'hFF is received correctly.
